// File: rtl/load_store_unit.sv
// Load/store unit: turns RISC-V byte-addressed load/store requests into word accesses
// on a single-port data memory, with read-modify-write for SB/SH and a fault code per response.
module load_store_unit #(
    parameter int MEM_WORDS = 11
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_fault,
    output logic        MEM_WE,
    output logic [31:0] MEM_A,
    output logic [31:0] MEM_WD,
    input  logic [31:0] MEM_RD
);

    typedef enum logic [1:0] {IDLE, RD_WORD, WR_WORD, RESP} state_t;

    localparam logic [29:0] C_MEM_WORDS = 30'(MEM_WORDS);

    state_t      r_state;
    state_t      w_next;
    logic        r_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merged;
    logic [31:0] r_rdata;
    logic [1:0]  r_fault;

    logic [1:0]  w_fault;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_loadData;
    logic [31:0] w_mergedData;

    // Fault classification of the incoming request; earlier checks take priority.
    always_comb begin
        w_fault = 2'b00;
        if (req_store ? (req_funct3 > 3'd2)
                      : (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7))
            w_fault = 2'b11;
        else if ((req_funct3 == 3'd2 && req_addr[1:0] != 2'b00) ||
                 ((req_funct3 == 3'd1 || req_funct3 == 3'd5) && req_addr[0]))
            w_fault = 2'b01;
        else if (req_addr[31:2] >= C_MEM_WORDS)
            w_fault = 2'b10;
    end

    // Lane extraction for loads and lane insertion for sub-word stores.
    always_comb begin
        w_byte       = MEM_RD[{r_addr[1:0], 3'b000} +: 8];
        w_half       = r_addr[1] ? MEM_RD[31:16] : MEM_RD[15:0];
        w_mergedData = MEM_RD;
        case (r_funct3)
            3'd0:    w_loadData = {{24{w_byte[7]}}, w_byte};
            3'd4:    w_loadData = {24'h000000, w_byte};
            3'd1:    w_loadData = {{16{w_half[15]}}, w_half};
            3'd5:    w_loadData = {16'h0000, w_half};
            default: w_loadData = MEM_RD;
        endcase
        if (r_funct3 == 3'd0)
            w_mergedData[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        else
            w_mergedData[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        MEM_WE     = 1'b0;
        MEM_A      = 32'h0;
        MEM_WD     = 32'h0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_fault != 2'b00)
                        w_next = RESP;
                    else if (req_store && req_funct3 == 3'd2)
                        w_next = WR_WORD;
                    else
                        w_next = RD_WORD;
                end
            end
            RD_WORD: begin
                MEM_A  = {r_addr[31:2], 2'b00};
                w_next = r_store ? WR_WORD : RESP;
            end
            WR_WORD: begin
                MEM_WE = 1'b1;
                MEM_A  = {r_addr[31:2], 2'b00};
                MEM_WD = (r_funct3 == 3'd2) ? r_wdata : r_merged;
                w_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request latch and response data; read data is cleared on accept so stores and faults report 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_store  <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_merged <= 32'h0;
            r_rdata  <= 32'h0;
            r_fault  <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_store  <= req_store;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_merged <= 32'h0;
                        r_rdata  <= 32'h0;
                        r_fault  <= w_fault;
                    end
                end
                RD_WORD: begin
                    if (r_store)
                        r_merged <= w_mergedData;
                    else
                        r_rdata <= w_loadData;
                end
                default: ;
            endcase
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_fault = r_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: a reference memory plus spec-level model
// predicts every response, write strobe and latency, with literal values pinning the model.
module tb_load_store_unit;

    localparam int MEM_WORDS = 11;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_fault;
    logic        MEM_WE;
    logic [31:0] MEM_A;
    logic [31:0] MEM_WD;
    logic [31:0] MEM_RD;

    logic [31:0] mem    [0:MEM_WORDS-1] = '{default: 32'h0};
    logic [31:0] refMem [0:MEM_WORDS-1] = '{default: 32'h0};

    int checks = 0;
    int errors = 0;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .MEM_WE(MEM_WE), .MEM_A(MEM_A), .MEM_WD(MEM_WD), .MEM_RD(MEM_RD)
    );

    always #5 CLK = ~CLK;

    assign MEM_RD = (int'(MEM_A[31:2]) < MEM_WORDS) ? mem[int'(MEM_A[31:2])] : 32'h0;

    always @(posedge CLK) begin
        if (MEM_WE && int'(MEM_A[31:2]) < MEM_WORDS)
            mem[int'(MEM_A[31:2])] <= MEM_WD;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic logic [1:0] modelFault(input logic st, input logic [2:0] f3, input logic [31:0] addr);
        if (st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6)) return 2'b11;
        if ((f3 == 3'd2 && addr % 4 != 0) || ((f3 == 3'd1 || f3 == 3'd5) && addr % 2 != 0)) return 2'b01;
        if (addr / 4 >= MEM_WORDS) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [2:0] f3, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'((word >> (8 * int'(off))) & 32'hFF);
        h = 16'((word >> (16 * int'(off / 2))) & 32'hFFFF);
        case (f3)
            3'd0:    return 32'($signed(b));
            3'd4:    return 32'(b);
            3'd1:    return 32'($signed(h));
            3'd5:    return 32'(h);
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] modelMerge(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] off, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        sh   = (f3 == 3'd0) ? 8 * int'(off) : 16 * int'(off / 2);
        mask = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << sh;
        return (word & ~mask) | ((wd << sh) & mask);
    endfunction

    // Drives one request, then checks every cycle until the response has been taken.
    task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, input int hold,
                                 input logic hasLit, input logic [31:0] lit);
        logic [1:0]  eFault;
        logic [31:0] eRdata, eWD, eA;
        logic        eWrite;
        int          lat, idx;
        eFault = modelFault(st, f3, addr);
        eA     = addr & 32'hFFFF_FFFC;
        idx    = int'(addr / 4);
        eRdata = 32'h0;
        eWD    = 32'h0;
        eWrite = 1'b0;
        if (eFault != 2'b00) begin
            lat = 1;
        end else if (st) begin
            eWrite = 1'b1;
            if (f3 == 3'd2) begin
                lat = 2;
                eWD = wd;
            end else begin
                lat = 3;
                eWD = modelMerge(refMem[idx], f3, addr[1:0], wd);
            end
            refMem[idx] = eWD;
        end else begin
            lat    = 2;
            eRdata = modelLoad(refMem[idx], f3, addr[1:0]);
        end
        if (hasLit) begin
            checkOutput("model rdata literal", eRdata, lit);
        end

        @(negedge CLK);
        checkOutput("req_ready before request", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge CLK);
        for (int k = 1; k <= lat; k++) begin
            @(negedge CLK);
            if (k == 1) req_valid = 1'b0;
            if (k < lat) begin
                checkOutput("resp_valid early", 32'(resp_valid), 32'd0);
                checkOutput("req_ready busy", 32'(req_ready), 32'd0);
                checkOutput("MEM_WE timing", 32'(MEM_WE), 32'(eWrite && k == lat - 1));
                checkOutput("MEM_A", MEM_A, eA);
                if (eWrite && k == lat - 1) checkOutput("MEM_WD", MEM_WD, eWD);
            end
        end
        checkOutput("resp_valid at latency", 32'(resp_valid), 32'd1);
        checkOutput("resp_rdata", resp_rdata, eRdata);
        checkOutput("resp_fault", 32'(resp_fault), 32'(eFault));
        checkOutput("MEM_WE in RESP", 32'(MEM_WE), 32'd0);
        if (hasLit) checkOutput("resp_rdata literal", resp_rdata, lit);
        for (int h = 0; h < hold; h++) begin
            req_valid  = 1'b1;
            req_store  = 1'b1;
            req_funct3 = 3'd2;
            req_addr   = 32'h0;
            req_wdata  = 32'h0000_0BAD;
            @(negedge CLK);
            checkOutput("hold resp_valid", 32'(resp_valid), 32'd1);
            checkOutput("hold resp_rdata", resp_rdata, eRdata);
            checkOutput("hold resp_fault", 32'(resp_fault), 32'(eFault));
            checkOutput("hold req_ready", 32'(req_ready), 32'd0);
            checkOutput("hold MEM_WE", 32'(MEM_WE), 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge CLK);
        resp_ready = 1'b0;
        checkOutput("resp_valid after transfer", 32'(resp_valid), 32'd0);
        checkOutput("req_ready after transfer", 32'(req_ready), 32'd1);
        for (int w = 0; w < 10 && !req_ready; w++) @(negedge CLK);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " req_ready"}, 32'(req_ready), 32'd1);
        checkOutput({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
        checkOutput({tag, " resp_rdata"}, resp_rdata, 32'h0);
        checkOutput({tag, " resp_fault"}, 32'(resp_fault), 32'd0);
        checkOutput({tag, " MEM_WE"}, 32'(MEM_WE), 32'd0);
        checkOutput({tag, " MEM_A"}, MEM_A, 32'h0);
        checkOutput({tag, " MEM_WD"}, MEM_WD, 32'h0);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        checkResetOutputs("reset");
        RST = 1'b0;

        applyStimulus(1'b1, 3'd2, 32'h08, 32'hDEADBEEF, 0, 1'b1, 32'h0);
        applyStimulus(1'b0, 3'd2, 32'h08, 32'h0, 0, 1'b1, 32'hDEADBEEF);
        applyStimulus(1'b1, 3'd0, 32'h09, 32'h123456AA, 0, 1'b1, 32'h0);
        checkOutput("mem word2 after SB", mem[2], 32'hDEADAAEF);
        checkOutput("model word2 after SB", refMem[2], 32'hDEADAAEF);
        applyStimulus(1'b0, 3'd0, 32'h09, 32'h0, 0, 1'b1, 32'hFFFFFFAA);
        applyStimulus(1'b0, 3'd4, 32'h09, 32'h0, 0, 1'b1, 32'h000000AA);
        applyStimulus(1'b0, 3'd1, 32'h0A, 32'h0, 0, 1'b1, 32'hFFFFDEAD);
        applyStimulus(1'b0, 3'd5, 32'h0A, 32'h0, 0, 1'b1, 32'h0000DEAD);
        applyStimulus(1'b1, 3'd1, 32'h0A, 32'h00007777, 0, 1'b1, 32'h0);
        checkOutput("mem word2 after SH", mem[2], 32'h7777AAEF);

        // Faults: misaligned, out of range, illegal funct3 (and its priority over misalignment).
        applyStimulus(1'b0, 3'd2, 32'h06, 32'h0, 0, 1'b0, 32'h0);
        applyStimulus(1'b1, 3'd1, 32'h03, 32'h5555, 0, 1'b0, 32'h0);
        applyStimulus(1'b0, 3'd2, 32'h2C, 32'h0, 0, 1'b0, 32'h0);
        applyStimulus(1'b0, 3'd3, 32'h08, 32'h0, 0, 1'b0, 32'h0);
        applyStimulus(1'b0, 3'd6, 32'h06, 32'h0, 0, 1'b0, 32'h0);
        applyStimulus(1'b1, 3'd4, 32'h08, 32'hFFFF, 0, 1'b0, 32'h0);
        applyStimulus(1'b1, 3'd0, 32'h2D, 32'hFF, 0, 1'b0, 32'h0);
        checkOutput("mem word2 after faults", mem[2], 32'h7777AAEF);
        applyStimulus(1'b0, 3'd2, 32'h28, 32'h0, 0, 1'b1, 32'h0);

        applyStimulus(1'b0, 3'd2, 32'h08, 32'h0, 3, 1'b1, 32'h7777AAEF);
        applyStimulus(1'b0, 3'd2, 32'h00, 32'h0, 0, 1'b1, 32'h0);

        applyStimulus(1'b1, 3'd2, 32'h04, 32'h11223344, 0, 1'b0, 32'h0);
        applyStimulus(1'b0, 3'd1, 32'h06, 32'h0, 0, 1'b1, 32'h00001122);
        applyStimulus(1'b0, 3'd0, 32'h07, 32'h0, 0, 1'b1, 32'h00000011);
        applyStimulus(1'b1, 3'd0, 32'h04, 32'h000000F0, 0, 1'b0, 32'h0);
        applyStimulus(1'b0, 3'd0, 32'h04, 32'h0, 0, 1'b1, 32'hFFFFFFF0);

        // Reset while the SB is reading its word: nothing may be written.
        @(negedge CLK);
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'd0;
        req_addr   = 32'h08;
        req_wdata  = 32'h000000CC;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        checkOutput("SB RD_WORD MEM_A", MEM_A, 32'h08);
        RST = 1'b1;
        #1;
        checkResetOutputs("mid-op reset");
        @(posedge CLK);
        #1;
        checkOutput("MEM_WE during reset", 32'(MEM_WE), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        checkOutput("mem word2 after aborted SB", mem[2], 32'h7777AAEF);
        applyStimulus(1'b0, 3'd2, 32'h08, 32'h0, 0, 1'b1, 32'h7777AAEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Core-side initiator for the word-addressed data memory.
- Accepts RISC-V load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) from the pipeline.
- Checks alignment, range and funct3. Drives word-aligned memory accesses, doing read-modify-write for sub-word stores.
- Returns sign/zero-extended load data and a fault code over a valid/ready response handshake.

Parameters:
- MEM_WORDS, 11, number of 32-bit words in the attached data memory; word index >= MEM_WORDS is out of range.

Ports:
- CLK  input  1  clock; all state changes on posedge.
- RST  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- req_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; low byte/half used for SB/SH.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  32  extended load data; 0 for stores and faults.
- resp_fault  output  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3.
- MEM_WE  output  1  memory write enable.
- MEM_A  output  32  memory byte address, always {word_index, 2'b00}.
- MEM_WD  output  32  memory write data.
- MEM_RD  input  32  memory read data, combinational from MEM_A.

Behaviour:
- States: IDLE, RD_WORD, WR_WORD, RESP.
- Reset (async, immediate):
  - state = IDLE; MEM_WE = 0; MEM_A = 0; MEM_WD = 0.
  - resp_valid = 0; resp_rdata = 0; resp_fault = 00; req_ready = 1.
  - All latched request fields cleared.
- IDLE: req_ready = 1. On req_valid, latch store, funct3, addr and wdata, then classify.
- Classification priority (first match wins):
  - Illegal funct3, fault 11: store with funct3 > 2, or load with funct3 in {3, 6, 7}.
  - Misaligned, fault 01: W with addr[1:0] != 0; H/HU with addr[0] != 0.
  - Out of range, fault 10: addr[31:2] >= MEM_WORDS.
  - Any fault goes to RESP with resp_rdata = 0. No memory access; MEM_WE never asserted.
- Next state for legal requests: SW goes to WR_WORD; all loads, SB and SH go to RD_WORD.
- RD_WORD (1 cycle): MEM_A = aligned address, MEM_WE = 0; capture MEM_RD.
  - Load: extract lane to resp_rdata, then go to RESP.
    - B/BU select byte addr[1:0]; H/HU select half addr[1].
    - B/H sign-extend; BU/HU zero-extend; W passes the word unchanged.
  - SB/SH: merge the low byte/half of wdata into the captured word at its lane, then go to WR_WORD.
- WR_WORD (1 cycle): MEM_WE = 1, MEM_A = aligned address, MEM_WD = full wdata (SW) or merged word. Then go to RESP.
- MEM_WE is high in WR_WORD only, for exactly one cycle per store.
- RESP: resp_valid = 1. resp_rdata and resp_fault are held stable until resp_ready.
  - Transfer occurs when resp_valid && resp_ready; next state IDLE.
- Request-to-resp_valid latency (request accepted at edge 0):
  - Fault: 1 cycle.
  - Load, SW: 2 cycles.
  - SB/SH: 3 cycles.
- req_ready is low outside IDLE; req_valid there is ignored and not queued.
- Back-to-back: if a response transfers in cycle n, a new request is accepted no earlier than cycle n+1.
- MEM_A and MEM_WD are don't-care in IDLE/RESP, but MEM_WE must be 0 there.
- Reset mid-operation: abandon the transaction; an interrupted RMW never writes. A write already committed in WR_WORD stays.

Test Plan:
- SW addr 0x08 data 0xDEADBEEF; then LW 0x08 -> MEM_WE high one cycle with MEM_A = 0x08; resp_valid 2 cycles after accept; rdata 0xDEADBEEF, fault 00.
- After the above, SB addr 0x09 data 0x123456AA -> memory word 2 = 0xDEADAAEF. Then LB 0x09 -> 0xFFFFFFAA; LBU 0x09 -> 0x000000AA; SB latency 3 cycles.
- LH 0x0A -> 0xFFFFDEAD; LHU 0x0A -> 0x0000DEAD. SH 0x0A data 0x00007777 -> word 2 = 0x7777AAEF.
- LW 0x06 -> fault 01; SH 0x03 -> fault 01; LW 0x2C (MEM_WORDS = 11) -> fault 10; load funct3 = 3 -> fault 11. In every case rdata 0, resp 1 cycle after accept, MEM_WE never high.
- Hold resp_ready low 3 cycles after an LW response -> resp_valid, rdata and fault stable; req_ready low; a concurrent req_valid is dropped. Release -> IDLE the next cycle.
- Assert RST during RD_WORD of SB 0x08 -> MEM_WE stays 0, word 2 unchanged, outputs return to reset values. A subsequent LW 0x08 returns the pre-SB value.
